wshb_mire_writer: RTL and testbench

Wishbone classic master that continuously writes a grid test pattern ("mire") into the SDRAM framebuffer. It is the upstream stage driving the `wshb_ifs_mire` port of `wshb_intercon`. It writes in bounded bursts and drops `cyc` between bursts so the arbiter can hand the bus to the VGA reader.

---
 rtl/mire_pkg.sv | 15 +
 rtl/wshb_if.sv | 33 +++
 rtl/mire_raster_cnt.sv | 52 +++++
 rtl/wshb_mire_writer.sv | 127 ++++++++++++
 tb/tb_wshb_mire_writer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mire_pkg.sv
// mire_pkg: shared definitions for the mire (grid test pattern) writer.
//   - mire_state_t : bus FSM states (idle, writing, one-cycle gap)
//   - MIRE_WHITE / MIRE_BLACK : pixel colours, top byte always zero
package mire_pkg;

  typedef enum logic [1:0] {
    MIRE_IDLE  = 2'd0,
    MIRE_WRITE = 2'd1,
    MIRE_GAP   = 2'd2
  } mire_state_t;

  localparam logic [31:0] MIRE_WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] MIRE_BLACK = 32'h0000_0000;

endpackage

// File: rtl/wshb_if.sv
// wshb_if: 32-bit Wishbone bus bundle.
//   clk, rst : bus clock/reset (carried for slaves; the mire writer uses its own)
//   master modport drives cyc/stb/we/adr/dat_ms/sel/cti/bte,
//   samples ack/err/rty/dat_sm. Slave modport is the mirror image.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, ack, err, rty, dat_sm,
    output cyc, stb, we, adr, dat_ms, sel, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, err, rty, dat_sm
  );

endinterface

// File: rtl/mire_raster_cnt.sv
// mire_raster_cnt: raster position and byte-address counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : step to the next pixel in raster order
//   x, y       : current pixel coordinates
//   adr        : BASE_ADDR + 4*(y*HDISP + x), kept as a running pointer
//   last       : current pixel is the final one of the frame
// HDISP and VDISP must both be at least 2.
module mire_raster_cnt #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          XW        = $clog2(HDISP),
  parameter int          YW        = $clog2(VDISP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [31:0]   adr,
  output logic          last
);

  logic x_end;

  assign x_end = (x == XW'(HDISP - 1));
  assign last  = x_end && (y == YW'(VDISP - 1));

  // The address walks linearly with the raster, so a +4 step replaces
  // the y*HDISP multiply; only the frame wrap reloads the base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      adr <= BASE_ADDR;
    end else if (advance) begin
      if (last) begin
        x   <= '0;
        y   <= '0;
        adr <= BASE_ADDR;
      end else if (x_end) begin
        x   <= '0;
        y   <= y + YW'(1);
        adr <= adr + 32'd4;
      end else begin
        x   <= x + XW'(1);
        adr <= adr + 32'd4;
      end
    end
  end

endmodule

// File: rtl/wshb_mire_writer.sv
// wshb_mire_writer: Wishbone classic master painting a grid test pattern
// into the framebuffer in bounded bursts.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   enable     : run while high; when low, finish the pending write and idle
//   frame_done : one-cycle pulse after the last pixel of a frame is acked
//   wshb_ifm   : Wishbone master port (ignores dat_sm and the bus clk/rst)
// cyc is released for one cycle after BURST_LEN terminations so the
// arbiter can serve other masters.
module wshb_mire_writer
  import mire_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          BURST_LEN = 64,
  parameter int          GRID      = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enable,
  output logic     frame_done,
  wshb_if.master   wshb_ifm
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST_LEN + 1);

  mire_state_t   state;
  mire_state_t   state_nxt;
  logic [BW-1:0] burst_cnt;
  logic          stb;
  logic          term;
  logic          accept;
  logic          burst_last;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic [31:0]   adr;
  logic [31:0]   dat;
  logic          last;

  // A pixel sits on the grid when either coordinate is a multiple of GRID;
  // GRID is a power of two so a mask test is enough.
  function automatic logic [31:0] pixel_colour(input logic [XW-1:0] px,
                                               input logic [YW-1:0] py);
    logic on_grid;
    on_grid = ((px & XW'(GRID - 1)) == '0) || ((py & YW'(GRID - 1)) == '0);
    return on_grid ? MIRE_WHITE : MIRE_BLACK;
  endfunction

  assign stb        = (state == MIRE_WRITE);
  assign term       = stb && (wshb_ifm.ack || wshb_ifm.err || wshb_ifm.rty);
  assign accept     = stb && wshb_ifm.ack;
  assign burst_last = (burst_cnt == BW'(BURST_LEN - 1));

  mire_raster_cnt #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .BASE_ADDR (BASE_ADDR)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
    .x       (x),
    .y       (y),
    .adr     (adr),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      MIRE_IDLE:  if (enable) state_nxt = MIRE_WRITE;
      MIRE_WRITE: if (term && (burst_last || !enable)) state_nxt = MIRE_GAP;
      MIRE_GAP:   state_nxt = enable ? MIRE_WRITE : MIRE_IDLE;
      default:    state_nxt = MIRE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MIRE_IDLE;
    else        state <= state_nxt;
  end

  // err/rty also count, so a misbehaving slave cannot stretch the tenure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (term) begin
      burst_cnt <= (state_nxt == MIRE_GAP) ? '0 : burst_cnt + BW'(1);
    end
  end

  // Coordinates of the pixel that follows the current one, used to
  // register its colour alongside the address step.
  always_comb begin
    x_nxt = x + XW'(1);
    y_nxt = y;
    if (x == XW'(HDISP - 1)) begin
      x_nxt = '0;
      y_nxt = last ? '0 : y + YW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat        <= MIRE_WHITE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last;
      if (accept) dat <= pixel_colour(x_nxt, y_nxt);
    end
  end

  assign wshb_ifm.cyc    = stb;
  assign wshb_ifm.stb    = stb;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.adr    = adr;
  assign wshb_ifm.dat_ms = dat;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;

endmodule

// File: tb/tb_wshb_mire_writer.sv
// tb_wshb_mire_writer: self-checking bench for wshb_mire_writer with a
// reduced 40x20 frame, a pixel-index reference model and a slave whose
// responses are chosen per cycle.
module tb_wshb_mire_writer;

  localparam int          H    = 40;
  localparam int          V    = 20;
  localparam int          BL   = 64;
  localparam int          G    = 16;
  localparam int          NPIX = H * V;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] WH   = 32'h00FF_FFFF;
  localparam logic [31:0] BK   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic frame_done;
  logic bus_rst;

  wshb_if bus (.clk(clk), .rst(bus_rst));

  wshb_mire_writer #(
    .HDISP(H), .VDISP(V), .BASE_ADDR(BASE), .BURST_LEN(BL), .GRID(G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_done (frame_done),
    .wshb_ifm   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] off;
    logic [31:0] dat;
  } wr_vec_t;

  wr_vec_t     tbl[12];
  int          total = 0;
  int          bad = 0;
  int          pix = 0;
  int          tcount = 0;
  bit          exp_stb = 1'b0;
  bit          logging = 1'b0;
  int          nlog = 0;
  int          cyc_n = 0;
  int          acc_since = 0;
  int          fd_seen = 0;
  logic [31:0] log_adr[0:1023];
  logic [31:0] log_dat[0:1023];
  int          log_cyc[0:1023];

  function automatic logic [31:0] pat(input int p);
    int px, py;
    px = p % H;
    py = p / H;
    return ((px % G) == 0 || (py % G) == 0) ? WH : BK;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // One clock cycle: check outputs against the model, present a slave
  // response, then update the model from the rules of the protocol.
  task automatic tick(input bit a, input bit e, input bit r);
    bit          s, en_s, lastpix;
    logic [31:0] adr_s, dat_s;
    s     = bus.stb;
    adr_s = bus.adr;
    dat_s = bus.dat_ms;
    chk("cyc_eq_stb", bus.cyc, bus.stb);
    chk("stb", s, exp_stb);
    if (s) begin
      chk("adr", adr_s, BASE + 32'(4 * pix));
      chk("dat", dat_s, pat(pix));
    end
    bus.ack = a;
    bus.err = e;
    bus.rty = r;
    en_s    = enable;
    @(posedge clk);
    #1;
    lastpix = s && a && (pix == NPIX - 1);
    if (s && a) begin
      if (logging && nlog < 1024) begin
        log_adr[nlog] = adr_s;
        log_dat[nlog] = dat_s;
        log_cyc[nlog] = cyc_n;
        nlog++;
      end
      pix = (pix + 1) % NPIX;
      acc_since++;
    end
    chk("frame_done", frame_done, lastpix);
    if (frame_done) begin
      chk("frame_len", acc_since, NPIX);
      acc_since = 0;
      fd_seen++;
    end
    if (s) begin
      if (a || e || r) begin
        tcount++;
        exp_stb = (tcount < BL) && en_s;
        if (!exp_stb) tcount = 0;
      end else begin
        exp_stb = 1'b1;
      end
    end else begin
      exp_stb = en_s;
    end
    cyc_n++;
    @(negedge clk);
    bus.ack = 1'b0;
    bus.err = 1'b0;
    bus.rty = 1'b0;
  endtask

  task automatic run_to(input int target, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * NPIX + 100; i++) begin
      if (bus.stb && pix == target) begin
        ok = 1'b1;
        break;
      end
      tick(1'b1, 1'b0, 1'b0);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    bit got;
    int r;
    rst_n      = 1'b0;
    enable     = 1'b0;
    bus_rst    = 1'b0;
    bus.ack    = 1'b0;
    bus.err    = 1'b0;
    bus.rty    = 1'b0;
    bus.dat_sm = 32'h0;

    tbl[0]  = '{0,   32'd0,    WH};
    tbl[1]  = '{1,   32'd4,    WH};
    tbl[2]  = '{40,  32'd160,  WH};
    tbl[3]  = '{41,  32'd164,  BK};
    tbl[4]  = '{56,  32'd224,  WH};
    tbl[5]  = '{57,  32'd228,  BK};
    tbl[6]  = '{64,  32'd256,  BK};
    tbl[7]  = '{640, 32'd2560, WH};
    tbl[8]  = '{656, 32'd2624, WH};
    tbl[9]  = '{681, 32'd2724, BK};
    tbl[10] = '{799, 32'd3196, BK};
    tbl[11] = '{800, 32'd0,    WH};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cyc", bus.cyc, 1'b0);
    chk("rst_stb", bus.stb, 1'b0);
    chk("rst_adr", bus.adr, BASE);
    chk("rst_dat", bus.dat_ms, WH);
    chk("rst_we", bus.we, 1'b1);
    chk("rst_sel", bus.sel, 4'hF);
    chk("rst_cti", bus.cti, 3'b000);
    chk("rst_bte", bus.bte, 2'b00);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    // Always-ack run over a full frame plus one write
    enable  = 1'b1;
    logging = 1'b1;
    for (int i = 0; i < 1200 && nlog < 801; i++) tick(1'b1, 1'b0, 1'b0);
    logging = 1'b0;
    chk("log_count", 32'(nlog >= 801), 32'd1);
    chk("frames_seen", 32'(fd_seen), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl_adr_%0d", tbl[i].n), log_adr[tbl[i].n], BASE + tbl[i].off);
      chk($sformatf("tbl_dat_%0d", tbl[i].n), log_dat[tbl[i].n], tbl[i].dat);
    end
    chk("back_to_back", 32'(log_cyc[63] - log_cyc[62]), 32'd1);
    chk("gap_after_64", 32'(log_cyc[64] - log_cyc[63]), 32'd2);

    // Three wait states on one write
    run_to(5, "reach_px5");
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("ws_stb", bus.stb, 1'b1);
    chk("ws_adr", bus.adr, BASE + 32'd20);
    tick(1'b1, 1'b0, 1'b0);

    // err on pixel (17,0), then ack
    run_to(17, "reach_px17");
    chk("err_adr", bus.adr, BASE + 32'd68);
    chk("err_dat", bus.dat_ms, WH);
    tick(1'b0, 1'b1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.stb) begin
        got = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 1'b0);
    end
    chk("reissue_seen", 32'(got), 32'd1);
    chk("reissue_adr", bus.adr, BASE + 32'd68);
    tick(1'b1, 1'b0, 1'b0);
    run_to(56, "reach_px56");
    chk("grid_x16_y1", bus.dat_ms, WH);
    tick(1'b1, 1'b0, 1'b0);
    chk("grid_x17_y1", bus.dat_ms, BK);

    // enable dropped while a write is stalled
    run_to(100, "reach_px100");
    enable = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("hold_stb", bus.stb, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("gap_stb", bus.stb, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    chk("idle_stb", bus.stb, 1'b0);
    enable = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("resume_adr", bus.adr, BASE + 32'd404);

    // Randomized slave responses and enable toggling
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      r = int'($urandom_range(0, 7));
      if (r <= 4)      tick(1'b1, 1'b0, 1'b0);
      else if (r == 5) tick(1'b0, 1'b1, 1'b0);
      else if (r == 6) tick(1'b0, 1'b0, 1'b1);
      else             tick(1'b0, 1'b0, 1'b0);
    end
    enable = 1'b1;

    // Asynchronous reset in the middle of a burst
    run_to((pix + 7) % NPIX, "reach_rst_point");
    chk("pre_rst_stb", bus.stb, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", bus.cyc, 1'b0);
    chk("arst_adr", bus.adr, BASE);
    chk("arst_dat", bus.dat_ms, WH);
    chk("arst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    pix       = 0;
    tcount    = 0;
    exp_stb   = 1'b0;
    acc_since = 0;
    tick(1'b1, 1'b0, 1'b0);
    chk("restart_stb", bus.stb, 1'b1);
    chk("restart_adr", bus.adr, BASE);
    repeat (10) tick(1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
